// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave that terminates one interconnect port with a word-addressed
// scratch memory. Read and write paths are independent FSMs; INCR and FIXED bursts up to 256
// beats; B/R responses echo the request ID.
//
// Build option: define AXI_MEM_ERR_CHECK_EN to answer SLVERR for size != 4 bytes, WRAP bursts
// and misplaced w_last. Without it every transfer is word-wide, WRAP behaves as INCR and all
// responses are OKAY.
//
// Ports:
//   clk, rst          sole clock, synchronous active-high reset
//   aw_* / w_* / b_*  write address, write data and write response channels
//   ar_* / r_*        read address and read data channels
//   *_user            ignored on input, driven 0 on output
module axi_mem_responder #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned MEM_DEPTH      = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    // AW
    input  logic                        aw_valid_i,
    output logic                        aw_ready_o,
    input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
    input  logic [7:0]                  aw_len_i,
    input  logic [2:0]                  aw_size_i,
    input  logic [1:0]                  aw_burst_i,
    input  logic [AXI_USER_WIDTH-1:0]   aw_user_i,
    // W
    input  logic                        w_valid_i,
    output logic                        w_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
    input  logic                        w_last_i,
    input  logic [AXI_USER_WIDTH-1:0]   w_user_i,
    // B
    output logic                        b_valid_o,
    input  logic                        b_ready_i,
    output logic [AXI_ID_WIDTH-1:0]     b_id_o,
    output logic [1:0]                  b_resp_o,
    output logic [AXI_USER_WIDTH-1:0]   b_user_o,
    // AR
    input  logic                        ar_valid_i,
    output logic                        ar_ready_o,
    input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
    input  logic [7:0]                  ar_len_i,
    input  logic [2:0]                  ar_size_i,
    input  logic [1:0]                  ar_burst_i,
    input  logic [AXI_USER_WIDTH-1:0]   ar_user_i,
    // R
    output logic                        r_valid_o,
    input  logic                        r_ready_i,
    output logic [AXI_ID_WIDTH-1:0]     r_id_o,
    output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
    output logic [1:0]                  r_resp_o,
    output logic                        r_last_o,
    output logic [AXI_USER_WIDTH-1:0]   r_user_o
);

    localparam int unsigned IdxW  = $clog2(MEM_DEPTH);
    localparam int unsigned StrbW = AXI_DATA_WIDTH / 8;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_e                w_state_q, w_state_d;
    logic                    aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, b_valid_q, b_valid_d;
    logic [AXI_ID_WIDTH-1:0] b_id_q, b_id_d;
    logic [1:0]              b_resp_q, b_resp_d;
    logic [IdxW-1:0]         w_idx_q, w_idx_d;
    logic [7:0]              w_len_q, w_len_d, w_beat_q, w_beat_d;
    logic                    w_fixed_q, w_fixed_d, w_err_q, w_err_d;

    r_state_e                r_state_q, r_state_d;
    logic                    ar_ready_q, ar_ready_d, r_valid_q, r_valid_d;
    logic [AXI_ID_WIDTH-1:0] r_id_q, r_id_d;
    logic [IdxW-1:0]         r_idx_q, r_idx_d;
    logic [7:0]              r_len_q, r_len_d, r_beat_q, r_beat_d;
    logic                    r_fixed_q, r_fixed_d, r_err_q, r_err_d;

    logic aw_err, ar_err, w_last_err, w_final, mem_we;

    assign w_final = (w_beat_q == w_len_q);

`ifdef AXI_MEM_ERR_CHECK_EN
    assign aw_err     = (aw_size_i != 3'd2) || (aw_burst_i == 2'b10);
    assign ar_err     = (ar_size_i != 3'd2) || (ar_burst_i == 2'b10);
    assign w_last_err = (w_last_i != w_final);
    logic unused_ok;
    assign unused_ok = ^{aw_user_i, w_user_i, ar_user_i,
                         aw_addr_i[AXI_ADDR_WIDTH-1:IdxW+2], aw_addr_i[1:0],
                         ar_addr_i[AXI_ADDR_WIDTH-1:IdxW+2], ar_addr_i[1:0]};
`else
    assign aw_err     = 1'b0;
    assign ar_err     = 1'b0;
    assign w_last_err = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{aw_user_i, w_user_i, ar_user_i, aw_size_i, ar_size_i, w_last_i,
                         aw_addr_i[AXI_ADDR_WIDTH-1:IdxW+2], aw_addr_i[1:0],
                         ar_addr_i[AXI_ADDR_WIDTH-1:IdxW+2], ar_addr_i[1:0]};
`endif

    // Write path
    always_comb begin
        w_state_d  = w_state_q;
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        b_valid_d  = b_valid_q;
        b_id_d     = b_id_q;
        b_resp_d   = b_resp_q;
        w_idx_d    = w_idx_q;
        w_len_d    = w_len_q;
        w_beat_d   = w_beat_q;
        w_fixed_d  = w_fixed_q;
        w_err_d    = w_err_q;
        mem_we     = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                // Raised one cycle after reset release, then held until an AW handshake.
                aw_ready_d = 1'b1;
                if (aw_valid_i && aw_ready_q) begin
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b1;
                    b_id_d     = aw_id_i;
                    w_idx_d    = aw_addr_i[IdxW+1:2];
                    w_len_d    = aw_len_i;
                    w_beat_d   = 8'd0;
                    w_fixed_d  = (aw_burst_i == BurstFixed);
                    w_err_d    = aw_err;
                    b_resp_d   = aw_err ? RespSlvErr : RespOkay;
                    w_state_d  = WData;
                end
            end
            WData: begin
                if (w_valid_i && w_ready_q) begin
                    mem_we = !w_err_q && !rst;
                    if (w_last_err) begin
                        b_resp_d = RespSlvErr;
                    end
                    if (w_final) begin
                        w_ready_d = 1'b0;
                        b_valid_d = 1'b1;
                        w_state_d = WResp;
                    end else begin
                        w_beat_d = w_beat_q + 8'd1;
                        if (!w_fixed_q) begin
                            w_idx_d = w_idx_q + 1'b1;
                        end
                    end
                end
            end
            WResp: begin
                if (b_valid_q && b_ready_i) begin
                    b_valid_d  = 1'b0;
                    aw_ready_d = 1'b1;
                    w_state_d  = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    // Read path
    always_comb begin
        r_state_d  = r_state_q;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_id_d     = r_id_q;
        r_idx_d    = r_idx_q;
        r_len_d    = r_len_q;
        r_beat_d   = r_beat_q;
        r_fixed_d  = r_fixed_q;
        r_err_d    = r_err_q;
        unique case (r_state_q)
            RIdle: begin
                ar_ready_d = 1'b1;
                if (ar_valid_i && ar_ready_q) begin
                    ar_ready_d = 1'b0;
                    r_valid_d  = 1'b1;
                    r_id_d     = ar_id_i;
                    r_idx_d    = ar_addr_i[IdxW+1:2];
                    r_len_d    = ar_len_i;
                    r_beat_d   = 8'd0;
                    r_fixed_d  = (ar_burst_i == BurstFixed);
                    r_err_d    = ar_err;
                    r_state_d  = RData;
                end
            end
            RData: begin
                if (r_valid_q && r_ready_i) begin
                    if (r_beat_q == r_len_q) begin
                        r_valid_d  = 1'b0;
                        ar_ready_d = 1'b1;
                        r_state_d  = RIdle;
                    end else begin
                        r_beat_d = r_beat_q + 8'd1;
                        if (!r_fixed_q) begin
                            r_idx_d = r_idx_q + 1'b1;
                        end
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q  <= WIdle;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            b_resp_q   <= RespOkay;
            w_idx_q    <= '0;
            w_len_q    <= 8'd0;
            w_beat_q   <= 8'd0;
            w_fixed_q  <= 1'b0;
            w_err_q    <= 1'b0;
            r_state_q  <= RIdle;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_id_q     <= '0;
            r_idx_q    <= '0;
            r_len_q    <= 8'd0;
            r_beat_q   <= 8'd0;
            r_fixed_q  <= 1'b0;
            r_err_q    <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_id_q     <= b_id_d;
            b_resp_q   <= b_resp_d;
            w_idx_q    <= w_idx_d;
            w_len_q    <= w_len_d;
            w_beat_q   <= w_beat_d;
            w_fixed_q  <= w_fixed_d;
            w_err_q    <= w_err_d;
            r_state_q  <= r_state_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_id_q     <= r_id_d;
            r_idx_q    <= r_idx_d;
            r_len_q    <= r_len_d;
            r_beat_q   <= r_beat_d;
            r_fixed_q  <= r_fixed_d;
            r_err_q    <= r_err_d;
        end
    end

    // Contents are not reset; a write in the same cycle as a read of that word lands at the
    // edge, so the combinational read port still shows the old value that cycle.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < StrbW; b++) begin
                if (w_strb_i[b]) begin
                    mem[w_idx_q][8*b +: 8] <= w_data_i[8*b +: 8];
                end
            end
        end
    end

    // Outputs are forced low while rst is high, including the first reset cycle.
    assign aw_ready_o = aw_ready_q & ~rst;
    assign w_ready_o  = w_ready_q & ~rst;
    assign b_valid_o  = b_valid_q & ~rst;
    assign b_id_o     = b_valid_o ? b_id_q : '0;
    assign b_resp_o   = b_valid_o ? b_resp_q : RespOkay;
    assign b_user_o   = '0;
    assign ar_ready_o = ar_ready_q & ~rst;
    assign r_valid_o  = r_valid_q & ~rst;
    assign r_id_o     = r_valid_o ? r_id_q : '0;
    assign r_data_o   = (r_valid_o && !r_err_q) ? mem[r_idx_q] : '0;
    assign r_resp_o   = (r_valid_o && r_err_q) ? RespSlvErr : RespOkay;
    assign r_last_o   = r_valid_o && (r_beat_q == r_len_q);
    assign r_user_o   = '0;

endmodule
